// File: rtl/alu_error_monitor_if.sv
// Bundle of the ALU-monitor operation inputs, board button and LED/status outputs.
interface alu_error_monitor_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             valid;
    logic [2:0]       seletor;
    logic [WIDTH-1:0] b;
    logic             sub_neg;
    logic             ovf;
    logic [3:0]       mask;
    logic             clear_btn;
    logic             err_pulse;
    logic             ledr9;
    logic [3:0]       first_cause;
    logic [3:0]       all_causes;
    logic [CNT_W-1:0] err_count;

    // Driver side: ALU datapath / opcode selector and pushbutton.
    modport master (
        output valid, seletor, b, sub_neg, ovf, mask, clear_btn,
        input  err_pulse, ledr9, first_cause, all_causes, err_count
    );

    // Monitor side.
    modport slave (
        input  valid, seletor, b, sub_neg, ovf, mask, clear_btn,
        output err_pulse, ledr9, first_cause, all_causes, err_count
    );
endinterface

// File: rtl/alu_error_monitor.sv
// Registered ALU error monitor: classifies issued operations, keeps a sticky error
// record (first cause, accumulated causes, saturating count) and drives the error LED.
module alu_error_monitor #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned BLINK_EN  = 1
) (
    input logic                clk,
    input logic                rst_n,
    alu_error_monitor_if.slave mon_io
);
    localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CntMax   = '1;

    typedef enum logic {StIdle, StError} state_e;

    state_e            state_q, state_d;
    logic [3:0]        first_q, first_d;
    logic [3:0]        all_q, all_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              led_q, led_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic              pulse_q, pulse_d;
    logic              clr_s1_q, clr_s2_q, clr_s3_q;

    logic [3:0] cause;
    logic [3:0] eff;
    logic [3:0] eff_first;
    logic       hit;
    logic       clr;

    // Raw causes are only meaningful on a valid strobe; masking gives the effective set.
    always_comb begin
        cause = 4'b0000;
        if (mon_io.valid) begin
            cause[0] = (mon_io.seletor == 3'b110) && (mon_io.b == '0);
            cause[1] = (mon_io.seletor == 3'b111);
            cause[2] = (mon_io.seletor == 3'b001) && mon_io.sub_neg;
            cause[3] = (mon_io.seletor == 3'b000) && mon_io.ovf;
        end
        eff       = cause & mon_io.mask;
        hit       = |eff;
        // Isolate the lowest set bit so c[0] wins when several causes coincide.
        eff_first = eff & (~eff + 4'd1);
    end

    // Two-flop synchronizer plus an edge-detect flop for the asynchronous clear button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            clr_s3_q <= 1'b0;
        end else begin
            clr_s1_q <= mon_io.clear_btn;
            clr_s2_q <= clr_s1_q;
            clr_s3_q <= clr_s2_q;
        end
    end

    assign clr = clr_s2_q & ~clr_s3_q;

    // Next-state: FSM transitions, cause/count recording and LED blink phase.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        all_d   = all_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        blink_d = blink_q;
        pulse_d = hit;
        unique case (state_q)
            StIdle: begin
                led_d   = 1'b0;
                blink_d = '0;
                if (hit) begin
                    state_d = StError;
                    first_d = eff_first;
                    all_d   = eff;
                    cnt_d   = CntOne;
                    led_d   = 1'b1;
                end
            end
            StError: begin
                // Free-running blink phase; new hits do not restart it.
                if (BLINK_EN != 0) begin
                    if (blink_q == BlinkMax) begin
                        blink_d = '0;
                        led_d   = ~led_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end else begin
                    led_d = 1'b1;
                end
                if (clr) begin
                    if (hit) begin
                        // Clear first, then record the hit as a fresh entry.
                        first_d = eff_first;
                        all_d   = eff;
                        cnt_d   = CntOne;
                        led_d   = 1'b1;
                        blink_d = '0;
                    end else begin
                        state_d = StIdle;
                        first_d = 4'b0000;
                        all_d   = 4'b0000;
                        cnt_d   = '0;
                        led_d   = 1'b0;
                        blink_d = '0;
                    end
                end else if (hit) begin
                    all_d = all_q | eff;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            first_q <= 4'b0000;
            all_q   <= 4'b0000;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            blink_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            all_q   <= all_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            blink_q <= blink_d;
            pulse_q <= pulse_d;
        end
    end

    assign mon_io.err_pulse   = pulse_q;
    assign mon_io.ledr9       = led_q;
    assign mon_io.first_cause = first_q;
    assign mon_io.all_causes  = all_q;
    assign mon_io.err_count   = cnt_q;
endmodule

// File: tb/tb_alu_error_monitor.sv
// Bench: dut_a blinks (BLINK_DIV=4) with a 2-bit counter; dut_b shares stimulus,
// holds the LED steady and has an 8-bit counter.
module tb_alu_error_monitor;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_error_monitor_if #(.WIDTH(4), .CNT_W(2)) bus_a ();
    alu_error_monitor_if #(.WIDTH(4), .CNT_W(8)) bus_b ();

    assign bus_b.valid     = bus_a.valid;
    assign bus_b.seletor   = bus_a.seletor;
    assign bus_b.b         = bus_a.b;
    assign bus_b.sub_neg   = bus_a.sub_neg;
    assign bus_b.ovf       = bus_a.ovf;
    assign bus_b.mask      = bus_a.mask;
    assign bus_b.clear_btn = bus_a.clear_btn;

    alu_error_monitor #(.WIDTH(4), .CNT_W(2), .BLINK_DIV(4), .BLINK_EN(1)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_io (bus_a)
    );

    alu_error_monitor #(.WIDTH(4), .CNT_W(8), .BLINK_DIV(4), .BLINK_EN(0)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_io (bus_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] sel;
        logic [3:0] b;
        logic       neg;
        logic       ovf;
        logic [3:0] mask;
        logic       pulse;
        logic [3:0] first;
        logic [3:0] all;
        logic [1:0] cnt_a;
        logic [7:0] cnt_b;
        logic       led_b;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] bb,
                         input logic n, input logic o, input logic [3:0] m);
        bus_a.valid   = v;
        bus_a.seletor = s;
        bus_a.b       = bb;
        bus_a.sub_neg = n;
        bus_a.ovf     = o;
        bus_a.mask    = m;
    endtask

    task automatic op(input logic [2:0] s, input logic [3:0] bb, input logic n,
                      input logic o, input logic [3:0] m);
        drive(1'b1, s, bb, n, o, m);
        step();
        drive(1'b0, 3'b010, 4'd5, 1'b0, 1'b0, 4'hF);
    endtask

    task automatic do_clear();
        bus_a.clear_btn = 1'b1;
        repeat (3) step();
        bus_a.clear_btn = 1'b0;
        repeat (2) step();
        chk("clear_cnt", 32'(bus_a.err_count), 32'd0);
        chk("clear_all", 32'(bus_a.all_causes), 32'd0);
    endtask

    initial begin
        logic exp_led[9];
        exp_led = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        //       v  sel     b   neg ovf mask   pulse first all   ca  cb  ledb
        vecs[0]  = '{1'b1, 3'b110, 4'd3, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 2'd0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 3'b110, 4'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 4'h1, 2'd1, 8'd1, 1'b1};
        vecs[2]  = '{1'b0, 3'b111, 4'd0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h1, 4'h1, 2'd1, 8'd1, 1'b1};
        vecs[3]  = '{1'b1, 3'b001, 4'd5, 1'b0, 1'b0, 4'hF, 1'b0, 4'h1, 4'h1, 2'd1, 8'd1, 1'b1};
        vecs[4]  = '{1'b1, 3'b001, 4'd5, 1'b1, 1'b0, 4'hF, 1'b1, 4'h1, 4'h5, 2'd2, 8'd2, 1'b1};
        vecs[5]  = '{1'b1, 3'b000, 4'd5, 1'b0, 1'b1, 4'h7, 1'b0, 4'h1, 4'h5, 2'd2, 8'd2, 1'b1};
        vecs[6]  = '{1'b1, 3'b000, 4'd5, 1'b0, 1'b1, 4'hF, 1'b1, 4'h1, 4'hD, 2'd3, 8'd3, 1'b1};
        vecs[7]  = '{1'b1, 3'b111, 4'd5, 1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 4'hF, 2'd3, 8'd4, 1'b1};
        vecs[8]  = '{1'b1, 3'b010, 4'd0, 1'b1, 1'b1, 4'hF, 1'b0, 4'h1, 4'hF, 2'd3, 8'd4, 1'b1};
        vecs[9]  = '{1'b1, 3'b110, 4'd0, 1'b0, 1'b0, 4'hE, 1'b0, 4'h1, 4'hF, 2'd3, 8'd4, 1'b1};
        vecs[10] = '{1'b1, 3'b110, 4'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 4'hF, 2'd3, 8'd5, 1'b1};

        rst_n = 1'b0;
        bus_a.clear_btn = 1'b0;
        drive(1'b0, 3'b010, 4'd5, 1'b0, 1'b0, 4'hF);
        #2;
        chk("rst_pulse", 32'(bus_a.err_pulse), 32'd0);
        chk("rst_led", 32'(bus_a.ledr9), 32'd0);
        chk("rst_first", 32'(bus_a.first_cause), 32'd0);
        chk("rst_all", 32'(bus_a.all_causes), 32'd0);
        chk("rst_cnt", 32'(bus_a.err_count), 32'd0);
        #10 rst_n = 1'b1;
        step();

        // Table: one operation per cycle, state carries from row to row.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].sel, vecs[i].b, vecs[i].neg, vecs[i].ovf, vecs[i].mask);
            step();
            chk($sformatf("v%0d_pulse", i), 32'(bus_a.err_pulse), 32'(vecs[i].pulse));
            chk($sformatf("v%0d_first", i), 32'(bus_a.first_cause), 32'(vecs[i].first));
            chk($sformatf("v%0d_all", i), 32'(bus_a.all_causes), 32'(vecs[i].all));
            chk($sformatf("v%0d_cnt_a", i), 32'(bus_a.err_count), 32'(vecs[i].cnt_a));
            chk($sformatf("v%0d_cnt_b", i), 32'(bus_b.err_count), 32'(vecs[i].cnt_b));
            chk($sformatf("v%0d_led_b", i), 32'(bus_b.ledr9), 32'(vecs[i].led_b));
        end
        drive(1'b0, 3'b010, 4'd5, 1'b0, 1'b0, 4'hF);
        step();
        chk("idle_pulse", 32'(bus_a.err_pulse), 32'd0);

        // Held clear button: exactly one clear, on the third edge after the press.
        bus_a.clear_btn = 1'b1;
        step();
        chk("clr_e1_first", 32'(bus_a.first_cause), 32'h1);
        step();
        chk("clr_e2_cnt", 32'(bus_a.err_count), 32'd3);
        step();
        chk("clr_e3_cnt_a", 32'(bus_a.err_count), 32'd0);
        chk("clr_e3_cnt_b", 32'(bus_b.err_count), 32'd0);
        chk("clr_e3_first", 32'(bus_a.first_cause), 32'd0);
        chk("clr_e3_all", 32'(bus_a.all_causes), 32'd0);
        chk("clr_e3_led_a", 32'(bus_a.ledr9), 32'd0);
        chk("clr_e3_led_b", 32'(bus_b.ledr9), 32'd0);
        op(3'b111, 4'd5, 1'b0, 1'b0, 4'hF);
        repeat (6) step();
        chk("held_first", 32'(bus_a.first_cause), 32'h2);
        chk("held_cnt", 32'(bus_a.err_count), 32'd1);
        bus_a.clear_btn = 1'b0;
        repeat (3) step();
        chk("release_cnt", 32'(bus_a.err_count), 32'd1);
        do_clear();

        // Three-cause sequence.
        op(3'b111, 4'd5, 1'b0, 1'b0, 4'hF);
        chk("seq_p1", 32'(bus_a.err_pulse), 32'd1);
        op(3'b001, 4'd5, 1'b1, 1'b0, 4'hF);
        chk("seq_p2", 32'(bus_a.err_pulse), 32'd1);
        op(3'b000, 4'd5, 1'b0, 1'b1, 4'hF);
        chk("seq_p3", 32'(bus_a.err_pulse), 32'd1);
        chk("seq_first", 32'(bus_a.first_cause), 32'h2);
        chk("seq_all", 32'(bus_a.all_causes), 32'hE);
        chk("seq_cnt", 32'(bus_a.err_count), 32'd3);
        do_clear();
        op(3'b111, 4'd5, 1'b0, 1'b0, 4'hF);
        op(3'b001, 4'd5, 1'b1, 1'b0, 4'hB);
        op(3'b000, 4'd5, 1'b0, 1'b1, 4'hF);
        chk("mseq_all", 32'(bus_a.all_causes), 32'hA);
        chk("mseq_cnt", 32'(bus_a.err_count), 32'd2);
        chk("mseq_first", 32'(bus_a.first_cause), 32'h2);
        do_clear();

        // Blink pattern with a second error mid-phase.
        drive(1'b1, 3'b111, 4'd5, 1'b0, 1'b0, 4'hF);
        for (int i = 0; i < 9; i++) begin
            step();
            drive(1'b0, 3'b010, 4'd5, 1'b0, 1'b0, 4'hF);
            chk($sformatf("blink_c%0d", i + 1), 32'(bus_a.ledr9), 32'(exp_led[i]));
            chk($sformatf("steady_c%0d", i + 1), 32'(bus_b.ledr9), 32'd1);
            if (i == 1) drive(1'b1, 3'b110, 4'd0, 1'b0, 1'b0, 4'hF);
        end
        chk("blink_cnt", 32'(bus_a.err_count), 32'd2);
        do_clear();

        // Clear edge and hit on the same cycle while in ERROR.
        op(3'b111, 4'd5, 1'b0, 1'b0, 4'hF);
        op(3'b001, 4'd5, 1'b1, 1'b0, 4'hF);
        chk("pre_sim_all", 32'(bus_a.all_causes), 32'h6);
        bus_a.clear_btn = 1'b1;
        repeat (2) step();
        op(3'b110, 4'd0, 1'b0, 1'b0, 4'hF);
        bus_a.clear_btn = 1'b0;
        chk("sim_all", 32'(bus_a.all_causes), 32'h1);
        chk("sim_first", 32'(bus_a.first_cause), 32'h1);
        chk("sim_cnt", 32'(bus_a.err_count), 32'd1);
        chk("sim_led", 32'(bus_a.ledr9), 32'd1);
        chk("sim_pulse", 32'(bus_a.err_pulse), 32'd1);
        step();
        chk("sim_stay", 32'(bus_a.first_cause), 32'h1);

        // Asynchronous reset in the middle of a clock period while in ERROR.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_led", 32'(bus_a.ledr9), 32'd0);
        chk("arst_cnt", 32'(bus_a.err_count), 32'd0);
        chk("arst_first", 32'(bus_a.first_cause), 32'd0);
        chk("arst_all", 32'(bus_a.all_causes), 32'd0);
        chk("arst_led_b", 32'(bus_b.ledr9), 32'd0);
        #3 rst_n = 1'b1;
        step();
        op(3'b001, 4'd5, 1'b1, 1'b0, 4'hF);
        chk("post_first", 32'(bus_a.first_cause), 32'h4);
        chk("post_all", 32'(bus_a.all_causes), 32'h4);
        chk("post_cnt", 32'(bus_a.err_count), 32'd1);
        chk("post_led", 32'(bus_a.ledr9), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
